mc_control: RTL and testbench
=============================

# mc_control

Multi-cycle control unit for the MIPS datapath: the sequential successor to the single-cycle decoder. It decodes `op`/`funct` from the instruction register and walks each instruction through FETCH/DECODE/EXEC/MEM/WB states. Memory-access states stretch by a parametrised latency. Datapath enables are issued per state. It sits between the IR and the datapath, driving PC, IR, register file, ALU, extender and data memory.

## Interface
- `MEM_LAT`, 0: extra wait cycles per IM/DM access; legal range 0..15.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `op`  in  6  IR[31:26], stable from DECODE until the next FETCH.
- `funct`  in  6  IR[5:0].
- `zero`  in  1  ALU equality flag, valid in EXEC.
- `mdu_busy`  in  1  multiply/divide unit busy (used only with `MDU_EN`).
- `pc_write`, `ir_write`, `reg_write`, `mem_write`  out  1 each  one-cycle write strobes.
- `pc_src`  out  2  00 PC+4, 01 branch target, 10 jump target, 11 GPR[rs].
- `alu_op`  out  4  0000 and, 0001 or, 0010 add, 0110 sub, 1110 xor, 1111 sll.
- `alu_src`  out  1  1 selects extended immediate.
- `ext_op`  out  2  00 zero-ext, 01 sign-ext, 10 load-upper.
- `reg_dst`  out  2  00 rt, 01 rd, 10 $31.
- `mem_to_reg`  out  2  00 ALU, 01 DM, 10 PC+4.
- `dm_op`  out  2  00 word, 01 byte, 10 half.
- `mdu_start`  out  1  one-cycle start pulse.
- `instr_done`  out  1  one-cycle pulse in an instruction's final cycle.
- `illegal`  out  1  one-cycle pulse in DECODE for an unsupported encoding.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, MDU_WAIT.
- IDLE goes to FETCH unconditionally on the first clock after reset release.
- FETCH lasts MEM_LAT+1 cycles, counted by a down-counter. `ir_write` and `pc_write` (pc_src=00) are asserted only in its last cycle. It then goes to DECODE.
- DECODE lasts 1 cycle.
  - Illegal encoding: pulse `illegal` and `instr_done`, then go to FETCH. The instruction acts as a nop.
  - Otherwise go to EXEC.
- EXEC by class:
  - R-ALU (addu 100001, subu 100011, and, or, xor, sll): go to WB.
  - ori, lui: go to WB.
  - lw/lb/lh/sw/sb/sh: address add with alu_src=1 and ext_op=01, then go to MEM.
  - beq/bne: sub. `pc_write` is asserted iff (beq & zero) | (bne & ~zero), with pc_src=01. Done.
  - j: `pc_write` with pc_src=10. Done.
  - jal: `pc_write` with pc_src=10, plus `reg_write`, reg_dst=10, mem_to_reg=10. Done.
  - jr: `pc_write` with pc_src=11. Done.
- MEM lasts MEM_LAT+1 cycles.
  - Stores assert `mem_write` only in the last cycle, then are done.
  - Loads go to WB after the last cycle.
- WB lasts 1 cycle and asserts `reg_write`.
  - reg_dst is 01 for R-type and 00 for I-type.
  - mem_to_reg is 01 for loads and 00 otherwise.
- Mux selects and `alu_op` are combinational in state and `op`/`funct`. They are don't-care outside the states that use them.
- `instr_done` coincides with the final cycle of every instruction.

## Timing
- Reset (asynchronous, any state including mid-MEM): state goes to IDLE and the counter clears.
  - All strobes, `instr_done`, `illegal` and `mdu_start` are 0.
  - All selects are 00 and alu_op is 0010.
  - A store interrupted mid-MEM never asserts `mem_write`.
- Cycles per instruction, with L = MEM_LAT:
  - branch/jump: L+3.
  - R/ori/lui: L+4.
  - store: 2L+4.
  - load: 2L+5.
  - illegal: L+2.
- At most one of `pc_write`/`mem_write`/`reg_write`/`ir_write` is asserted per cycle. Exceptions: jal (pc_write with reg_write) and FETCH (pc_write with ir_write).

## Configuration
- `MC_CONTROL_MDU_EN` defined:
  - mult 011000, multu 011001, div 011010 and divu 011011 pulse `mdu_start` in EXEC, then go to MDU_WAIT.
  - MDU_WAIT holds while `mdu_busy`=1. The first cycle it sees `mdu_busy`=0 is the final cycle, with `instr_done`.
  - mfhi 010000 and mflo 010010 stall in EXEC while `mdu_busy`=1, then go to WB.
- Undefined: those funct codes are illegal, and `mdu_start` is tied to 0.

## Test plan
- Reset held, then released, with MEM_LAT=0 → one IDLE cycle. Next cycle, FETCH has pc_write=1 and ir_write=1. Assert reset_n low mid-sequence → all outputs 0 asynchronously.
- addu (op 0, funct 100001) with MEM_LAT=0 → reg_write=1 with reg_dst=01 on cycle 4 only. instr_done on cycle 4.
- lw with MEM_LAT=2 → 9 cycles. reg_write with mem_to_reg=01 only in the last cycle.
- sw with MEM_LAT=2 → mem_write high exactly once, in cycle 8. Reset asserted in cycle 7 → mem_write never asserted.
- beq with zero=0, then zero=1 → pc_write 0 then 1 in EXEC (pc_src=01). jal → pc_write, reg_write, reg_dst=10 and mem_to_reg=10 together.
- With MDU_EN: mult with mdu_busy held high 5 cycles → single mdu_start, instr_done when busy falls. Without MDU_EN: mult → illegal pulse in DECODE.

Source files
------------

// File: rtl/mc_control_if.sv
// mc_control_if: datapath-facing bundle for the multi-cycle control unit.
// The control unit (master) consumes IR fields and datapath status flags and
// drives every datapath enable and mux select; the datapath side (slave)
// supplies op/funct/zero/mdu_busy and consumes the controls.
interface mc_control_if;
  // Inputs to the control unit
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mdu_busy;
  // Write strobes and pulses
  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_write;
  logic       mdu_start;
  logic       instr_done;
  logic       illegal;
  // Mux selects and ALU control
  logic [1:0] pc_src;
  logic [3:0] alu_op;
  logic       alu_src;
  logic [1:0] ext_op;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic [1:0] dm_op;

  modport master (
    input  op, funct, zero, mdu_busy,
    output pc_write, ir_write, reg_write, mem_write, mdu_start, instr_done,
           illegal, pc_src, alu_op, alu_src, ext_op, reg_dst, mem_to_reg, dm_op
  );

  modport slave (
    output op, funct, zero, mdu_busy,
    input  pc_write, ir_write, reg_write, mem_write, mdu_start, instr_done,
           illegal, pc_src, alu_op, alu_src, ext_op, reg_dst, mem_to_reg, dm_op
  );
endinterface

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB/MDU_WAIT).
// FETCH and MEM stretch to MEM_LAT+1 cycles via a down-counter. All outputs are
// combinational in the current state and the IR fields, so an asynchronous
// reset forces every strobe low immediately.
// Optional feature: define MC_CONTROL_MDU_EN to decode mult/multu/div/divu and
// mfhi/mflo; otherwise those encodings are illegal and mdu_start stays 0.
//
// Pulse protocol: instr_done is high for exactly one cycle, the final cycle of
// each instruction; the following cycle is always the first FETCH cycle of the
// next instruction. illegal is high for one cycle in DECODE, together with
// instr_done, and the instruction has no other side effect.
module mc_control #(
  parameter int MEM_LAT = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  mc_control_if.master     bus,
  output logic [2:0]       dbg_state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_DECODE   = 3'd2;
  localparam logic [2:0] S_EXEC     = 3'd3;
  localparam logic [2:0] S_MEM      = 3'd4;
  localparam logic [2:0] S_WB       = 3'd5;
  localparam logic [2:0] S_MDU_WAIT = 3'd6;

  // Instruction classes produced by the decoder
  localparam logic [3:0] C_ILL   = 4'd0;
  localparam logic [3:0] C_RALU  = 4'd1;
  localparam logic [3:0] C_IMM   = 4'd2;
  localparam logic [3:0] C_LOAD  = 4'd3;
  localparam logic [3:0] C_STORE = 4'd4;
  localparam logic [3:0] C_BR    = 4'd5;
  localparam logic [3:0] C_J     = 4'd6;
  localparam logic [3:0] C_JAL   = 4'd7;
  localparam logic [3:0] C_JR    = 4'd8;
  localparam logic [3:0] C_MDU   = 4'd9;
  localparam logic [3:0] C_MF    = 4'd10;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [3:0] cls;
  logic [3:0] dec_alu_op;
  logic       dec_alu_src;
  logic [1:0] dec_ext_op;
  logic [1:0] dec_dm_op;
  logic       is_rtype;
  logic       br_taken;

  assign dbg_state = state_q;
  assign is_rtype  = (bus.op == 6'b000000);
  assign br_taken  = ((bus.op == 6'b000100) &  bus.zero) |
                     ((bus.op == 6'b000101) & ~bus.zero);

  // Decode op/funct into an instruction class plus ALU/extender/DM controls
  always_comb begin
    cls         = C_ILL;
    dec_alu_op  = 4'b0010;
    dec_alu_src = 1'b0;
    dec_ext_op  = 2'b00;
    dec_dm_op   = 2'b00;
    case (bus.op)
      6'b000000: begin
        case (bus.funct)
          6'b100001: begin cls = C_RALU; dec_alu_op = 4'b0010; end
          6'b100011: begin cls = C_RALU; dec_alu_op = 4'b0110; end
          6'b100100: begin cls = C_RALU; dec_alu_op = 4'b0000; end
          6'b100101: begin cls = C_RALU; dec_alu_op = 4'b0001; end
          6'b100110: begin cls = C_RALU; dec_alu_op = 4'b1110; end
          6'b000000: begin cls = C_RALU; dec_alu_op = 4'b1111; end
          6'b001000: cls = C_JR;
`ifdef MC_CONTROL_MDU_EN
          6'b011000, 6'b011001, 6'b011010, 6'b011011: cls = C_MDU;
          6'b010000, 6'b010010:                       cls = C_MF;
`endif
          default: cls = C_ILL;
        endcase
      end
      6'b001101: begin
        cls = C_IMM; dec_alu_op = 4'b0001; dec_alu_src = 1'b1; dec_ext_op = 2'b00;
      end
      // lui: extender places imm in the upper half; OR with rs ($zero) passes it
      6'b001111: begin
        cls = C_IMM; dec_alu_op = 4'b0001; dec_alu_src = 1'b1; dec_ext_op = 2'b10;
      end
      6'b100011, 6'b100000, 6'b100001,
      6'b101011, 6'b101000, 6'b101001: begin
        cls         = bus.op[3] ? C_STORE : C_LOAD;
        dec_alu_op  = 4'b0010;
        dec_alu_src = 1'b1;
        dec_ext_op  = 2'b01;
        case (bus.op[2:0])
          3'b000:  dec_dm_op = 2'b01;
          3'b001:  dec_dm_op = 2'b10;
          default: dec_dm_op = 2'b00;
        endcase
      end
      6'b000100, 6'b000101: begin cls = C_BR; dec_alu_op = 4'b0110; end
      6'b000010: cls = C_J;
      6'b000011: cls = C_JAL;
      default:   cls = C_ILL;
    endcase
  end

  // Next-state, latency counter and per-state datapath controls
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mdu_start  = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;
    bus.pc_src     = 2'b00;
    bus.alu_op     = 4'b0010;
    bus.alu_src    = 1'b0;
    bus.ext_op     = 2'b00;
    bus.reg_dst    = 2'b00;
    bus.mem_to_reg = 2'b00;
    bus.dm_op      = 2'b00;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        cnt_d   = LAT;
      end
      S_FETCH: begin
        if (cnt_q == 4'd0) begin
          bus.pc_write = 1'b1;
          bus.ir_write = 1'b1;
          state_d      = S_DECODE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DECODE: begin
        if (cls == C_ILL) begin
          bus.illegal    = 1'b1;
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
          cnt_d          = LAT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        bus.alu_op  = dec_alu_op;
        bus.alu_src = dec_alu_src;
        bus.ext_op  = dec_ext_op;
        case (cls)
          C_RALU, C_IMM: state_d = S_WB;
          C_LOAD, C_STORE: begin
            state_d = S_MEM;
            cnt_d   = LAT;
          end
          C_BR, C_J, C_JAL, C_JR: begin
            bus.instr_done = 1'b1;
            state_d        = S_FETCH;
            cnt_d          = LAT;
            case (cls)
              C_BR:  begin bus.pc_src = 2'b01; bus.pc_write = br_taken; end
              C_J:   begin bus.pc_src = 2'b10; bus.pc_write = 1'b1; end
              C_JAL: begin
                bus.pc_src     = 2'b10;
                bus.pc_write   = 1'b1;
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 2'b10;
                bus.mem_to_reg = 2'b10;
              end
              default: begin bus.pc_src = 2'b11; bus.pc_write = 1'b1; end
            endcase
          end
          C_MDU: begin
            bus.mdu_start = 1'b1;
            state_d       = S_MDU_WAIT;
          end
          // mfhi/mflo wait here until the MDU has a result
          C_MF: begin
            if (!bus.mdu_busy) state_d = S_WB;
          end
          default: begin
            state_d = S_FETCH;
            cnt_d   = LAT;
          end
        endcase
      end
      S_MEM: begin
        bus.alu_op  = dec_alu_op;
        bus.alu_src = dec_alu_src;
        bus.ext_op  = dec_ext_op;
        bus.dm_op   = dec_dm_op;
        if (cnt_q == 4'd0) begin
          if (cls == C_STORE) begin
            bus.mem_write  = 1'b1;
            bus.instr_done = 1'b1;
            state_d        = S_FETCH;
            cnt_d          = LAT;
          end else begin
            state_d = S_WB;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WB: begin
        bus.alu_op     = dec_alu_op;
        bus.alu_src    = dec_alu_src;
        bus.ext_op     = dec_ext_op;
        bus.reg_write  = 1'b1;
        bus.reg_dst    = is_rtype ? 2'b01 : 2'b00;
        bus.mem_to_reg = (cls == C_LOAD) ? 2'b01 : 2'b00;
        bus.instr_done = 1'b1;
        state_d        = S_FETCH;
        cnt_d          = LAT;
      end
      S_MDU_WAIT: begin
        if (!bus.mdu_busy) begin
          bus.instr_done = 1'b1;
          state_d        = S_FETCH;
          cnt_d          = LAT;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and counter registers; reset returns to IDLE with the counter cleared
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: scoreboard bench for mc_control. The driver issues one
// instruction at a time and pushes the expected per-instruction trace summary;
// the monitor accumulates what the DUT does and compares at each instr_done.
module tb_mc_control;
  localparam int L = 2;

  // Instruction classes of the reference model
  localparam int K_ILL = 0, K_RALU = 1, K_ORI = 2, K_LUI = 3, K_LOAD = 4,
                 K_STORE = 5, K_BR = 6, K_J = 7, K_JAL = 8, K_JR = 9,
                 K_MULT = 10, K_MF = 11;

  typedef struct packed {
    logic [6:0] cycles;
    logic [1:0] pcw_cnt;
    logic [6:0] pcw1_cyc;
    logic [1:0] pcw1_src;
    logic [6:0] pcw2_cyc;
    logic [1:0] pcw2_src;
    logic [1:0] irw_cnt;
    logic [6:0] irw_cyc;
    logic [1:0] regw_cnt;
    logic [6:0] regw_cyc;
    logic [1:0] reg_dst;
    logic [1:0] m2r;
    logic [1:0] memw_cnt;
    logic [6:0] memw_cyc;
    logic [1:0] ill_cnt;
    logic [1:0] mds_cnt;
    logic [6:0] mds_cyc;
    logic [1:0] viol_cnt;
    logic       op_chk;
    logic [3:0] alu_op;
    logic       src_chk;
    logic       alu_src;
    logic       ext_chk;
    logic [1:0] ext_op;
    logic       dm_chk;
    logic [1:0] dm_op;
  } rec_t;
  localparam int REC_W = $bits(rec_t);

  // Clock / reset
  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  mc_control_if bus ();

  mc_control #(.MEM_LAT(L)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  logic [REC_W-1:0] exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  bit  mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t state=%0d)", name, act, exp, $time, dbg_state);
    end
  endtask

  task automatic report_and_finish();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  // ---------------- reference model ----------------
  function automatic int classify(input logic [5:0] op, input logic [5:0] funct);
    int k;
    k = K_ILL;
    if (op == 6'b000000) begin
      case (funct)
        6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100110, 6'b000000: k = K_RALU;
        6'b001000: k = K_JR;
`ifdef MC_CONTROL_MDU_EN
        6'b011000, 6'b011001, 6'b011010, 6'b011011: k = K_MULT;
        6'b010000, 6'b010010: k = K_MF;
`endif
        default: k = K_ILL;
      endcase
    end else begin
      case (op)
        6'b001101: k = K_ORI;
        6'b001111: k = K_LUI;
        6'b100011, 6'b100000, 6'b100001: k = K_LOAD;
        6'b101011, 6'b101000, 6'b101001: k = K_STORE;
        6'b000100, 6'b000101: k = K_BR;
        6'b000010: k = K_J;
        6'b000011: k = K_JAL;
        default:   k = K_ILL;
      endcase
    end
    return k;
  endfunction

  function automatic logic [3:0] alu_for_funct(input logic [5:0] funct);
    case (funct)
      6'b100011: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100110: return 4'b1110;
      6'b000000: return 4'b1111;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic logic [1:0] dm_for_op(input logic [5:0] op);
    case (op)
      6'b100000, 6'b101000: return 2'b01;
      6'b100001, 6'b101001: return 2'b10;
      default:              return 2'b00;
    endcase
  endfunction

  // Expected trace: cycle numbers are 1-based from the first FETCH cycle
  function automatic rec_t model(input logic [5:0] op, input logic [5:0] funct,
                                 input logic zero, input int b);
    rec_t r;
    int   k;
    r = '0;
    k = classify(op, funct);
    r.pcw_cnt  = 2'd1;
    r.pcw1_cyc = 7'(L + 1);
    r.irw_cnt  = 2'd1;
    r.irw_cyc  = 7'(L + 1);
    case (k)
      K_ILL: begin
        r.cycles  = 7'(L + 2);
        r.ill_cnt = 2'd1;
      end
      K_RALU, K_ORI, K_LUI: begin
        r.cycles   = 7'(L + 4);
        r.regw_cnt = 2'd1;
        r.regw_cyc = 7'(L + 4);
        r.reg_dst  = (k == K_RALU) ? 2'b01 : 2'b00;
        r.src_chk  = 1'b1;
        r.alu_src  = (k != K_RALU);
        if (k == K_RALU) begin r.op_chk = 1'b1; r.alu_op = alu_for_funct(funct); end
        if (k == K_ORI)  begin r.op_chk = 1'b1; r.alu_op = 4'b0001; r.ext_chk = 1'b1; r.ext_op = 2'b00; end
        if (k == K_LUI)  begin r.ext_chk = 1'b1; r.ext_op = 2'b10; end
      end
      K_LOAD, K_STORE: begin
        r.op_chk  = 1'b1; r.alu_op  = 4'b0010;
        r.src_chk = 1'b1; r.alu_src = 1'b1;
        r.ext_chk = 1'b1; r.ext_op  = 2'b01;
        r.dm_chk  = 1'b1; r.dm_op   = dm_for_op(op);
        if (k == K_LOAD) begin
          r.cycles   = 7'(2 * L + 5);
          r.regw_cnt = 2'd1;
          r.regw_cyc = 7'(2 * L + 5);
          r.m2r      = 2'b01;
        end else begin
          r.cycles   = 7'(2 * L + 4);
          r.memw_cnt = 2'd1;
          r.memw_cyc = 7'(2 * L + 4);
        end
      end
      K_BR: begin
        r.cycles  = 7'(L + 3);
        r.op_chk  = 1'b1; r.alu_op = 4'b0110;
        r.src_chk = 1'b1; r.alu_src = 1'b0;
        if ((op == 6'b000100 && zero) || (op == 6'b000101 && !zero)) begin
          r.pcw_cnt  = 2'd2;
          r.pcw2_cyc = 7'(L + 3);
          r.pcw2_src = 2'b01;
        end
      end
      K_J, K_JAL, K_JR: begin
        r.cycles   = 7'(L + 3);
        r.pcw_cnt  = 2'd2;
        r.pcw2_cyc = 7'(L + 3);
        r.pcw2_src = (k == K_JR) ? 2'b11 : 2'b10;
        if (k == K_JAL) begin
          r.regw_cnt = 2'd1;
          r.regw_cyc = 7'(L + 3);
          r.reg_dst  = 2'b10;
          r.m2r      = 2'b10;
        end
      end
      K_MULT: begin
        r.cycles  = 7'(L + 4 + b);
        r.mds_cnt = 2'd1;
        r.mds_cyc = 7'(L + 3);
      end
      default: begin  // K_MF
        r.cycles   = 7'(L + 4 + b);
        r.regw_cnt = 2'd1;
        r.regw_cyc = 7'(L + 4 + b);
        r.reg_dst  = 2'b01;
      end
    endcase
    return r;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  rec_t obs;
  int   cyc;
  always begin
    @(negedge clk);
    #2;
    if (!(mon_en && reset_n)) begin
      obs = '0;
      cyc = 0;
    end else begin
      int   n_str;
      rec_t e;
      cyc++;
      if (bus.pc_write) begin
        if (obs.pcw_cnt == 2'd0) begin obs.pcw1_cyc = 7'(cyc); obs.pcw1_src = bus.pc_src; end
        else begin obs.pcw2_cyc = 7'(cyc); obs.pcw2_src = bus.pc_src; end
        if (obs.pcw_cnt != 2'd3) obs.pcw_cnt++;
      end
      if (bus.ir_write) begin
        obs.irw_cyc = 7'(cyc);
        if (obs.irw_cnt != 2'd3) obs.irw_cnt++;
      end
      if (bus.reg_write) begin
        obs.regw_cyc = 7'(cyc); obs.reg_dst = bus.reg_dst; obs.m2r = bus.mem_to_reg;
        if (obs.regw_cnt != 2'd3) obs.regw_cnt++;
      end
      if (bus.mem_write) begin
        obs.memw_cyc = 7'(cyc);
        if (obs.memw_cnt != 2'd3) obs.memw_cnt++;
      end
      if (bus.illegal && obs.ill_cnt != 2'd3) obs.ill_cnt++;
      if (bus.mdu_start) begin
        obs.mds_cyc = 7'(cyc);
        if (obs.mds_cnt != 2'd3) obs.mds_cnt++;
      end
      n_str = int'(bus.pc_write) + int'(bus.ir_write) + int'(bus.reg_write) + int'(bus.mem_write);
      if (n_str > 1 && !(n_str == 2 && bus.pc_write && (bus.ir_write || bus.reg_write)))
        if (obs.viol_cnt != 2'd3) obs.viol_cnt++;
      if (cyc == L + 3) begin
        obs.alu_op = bus.alu_op; obs.alu_src = bus.alu_src; obs.ext_op = bus.ext_op;
      end
      if (cyc == 2 * L + 4) obs.dm_op = bus.dm_op;

      if (bus.instr_done || cyc > 100) begin
        obs.cycles = 7'(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = rec_t'(exp_q.pop_front());
          chk("cycles", 32'(obs.cycles), 32'(e.cycles));
          chk("pc_write", 32'({obs.pcw_cnt, obs.pcw1_cyc, obs.pcw1_src, obs.pcw2_cyc, obs.pcw2_src}),
                          32'({e.pcw_cnt, e.pcw1_cyc, e.pcw1_src, e.pcw2_cyc, e.pcw2_src}));
          chk("ir_write", 32'({obs.irw_cnt, obs.irw_cyc}), 32'({e.irw_cnt, e.irw_cyc}));
          chk("reg_write", 32'({obs.regw_cnt, obs.regw_cyc, obs.reg_dst, obs.m2r}),
                           32'({e.regw_cnt, e.regw_cyc, e.reg_dst, e.m2r}));
          chk("mem_write", 32'({obs.memw_cnt, obs.memw_cyc}), 32'({e.memw_cnt, e.memw_cyc}));
          chk("illegal", 32'(obs.ill_cnt), 32'(e.ill_cnt));
          chk("mdu_start", 32'({obs.mds_cnt, obs.mds_cyc}), 32'({e.mds_cnt, e.mds_cyc}));
          chk("strobe_overlap", 32'(obs.viol_cnt), 32'(e.viol_cnt));
          if (e.op_chk)  chk("alu_op", 32'(obs.alu_op), 32'(e.alu_op));
          if (e.src_chk) chk("alu_src", 32'(obs.alu_src), 32'(e.alu_src));
          if (e.ext_chk) chk("ext_op", 32'(obs.ext_op), 32'(e.ext_op));
          if (e.dm_chk)  chk("dm_op", 32'(obs.dm_op), 32'(e.dm_op));
        end
        obs = '0;
        cyc = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Call on the negedge that opens the first FETCH cycle; returns on the
  // negedge opening the next instruction's first FETCH cycle.
  task automatic issue(input logic [5:0] op, input logic [5:0] funct,
                       input logic zero, input int b);
    int k, cls, hold;
    bit done;
    cls = classify(op, funct);
    exp_q.push_back(model(op, funct, zero, b));
    hold = (cls == K_MULT) ? L + 3 + b : (cls == K_MF) ? L + 2 + b : 0;
    bus.op = op; bus.funct = funct; bus.zero = zero;
    k = 1;
    done = 1'b0;
    while (!done && k <= 64) begin
      if (cls == K_MULT || cls == K_MF) bus.mdu_busy = (k <= hold);
      else bus.mdu_busy = 1'($urandom_range(0, 1));
      #1;
      done = bus.instr_done;
      @(negedge clk);
      k++;
    end
    if (!done) begin
      chk("instr_done_timeout", 32'd0, 32'd1);
      report_and_finish();
    end
  endtask

  task automatic check_quiet(input string name);
    chk(name, 32'({bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write,
                   bus.mdu_start, bus.instr_done, bus.illegal, bus.pc_src, bus.alu_src,
                   bus.ext_op, bus.reg_dst, bus.mem_to_reg, bus.dm_op, bus.alu_op}),
              32'({7'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0010}));
  endtask

  // Release reset just after a posedge: one IDLE cycle, then FETCH
  task automatic release_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    #1 check_quiet("idle_cycle");
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  logic [11:0] legal_tab [0:24] = '{
    {6'b000000, 6'b100001}, {6'b000000, 6'b100011}, {6'b000000, 6'b100100},
    {6'b000000, 6'b100101}, {6'b000000, 6'b100110}, {6'b000000, 6'b000000},
    {6'b000000, 6'b001000}, {6'b000000, 6'b011000}, {6'b000000, 6'b011001},
    {6'b000000, 6'b011010}, {6'b000000, 6'b011011}, {6'b000000, 6'b010000},
    {6'b000000, 6'b010010}, {6'b001101, 6'b000000}, {6'b001111, 6'b000000},
    {6'b100011, 6'b000000}, {6'b100000, 6'b000000}, {6'b100001, 6'b000000},
    {6'b101011, 6'b000000}, {6'b101000, 6'b000000}, {6'b101001, 6'b000000},
    {6'b000100, 6'b000000}, {6'b000101, 6'b000000}, {6'b000010, 6'b000000},
    {6'b000011, 6'b000000}
  };

  // ---------------- main sequence ----------------
  initial begin
    int mw_seen;
    logic [11:0] pick;
    reset_n = 1'b0;
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.mdu_busy = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_quiet("reset_hold");
    release_reset();

    // Directed: every class and the branch/jump corner cases
    issue(6'b000000, 6'b100001, 1'b0, 0);  // addu
    issue(6'b100011, 6'b000000, 1'b0, 0);  // lw
    issue(6'b101011, 6'b000000, 1'b0, 0);  // sw
    issue(6'b000100, 6'b000000, 1'b0, 0);  // beq not taken
    issue(6'b000100, 6'b000000, 1'b1, 0);  // beq taken
    issue(6'b000101, 6'b000000, 1'b0, 0);  // bne taken
    issue(6'b000101, 6'b000000, 1'b1, 0);  // bne not taken
    issue(6'b000011, 6'b000000, 1'b0, 0);  // jal
    issue(6'b000010, 6'b000000, 1'b0, 0);  // j
    issue(6'b000000, 6'b001000, 1'b0, 0);  // jr
    issue(6'b001101, 6'b000000, 1'b0, 0);  // ori
    issue(6'b001111, 6'b000000, 1'b0, 0);  // lui
    issue(6'b100000, 6'b000000, 1'b0, 0);  // lb
    issue(6'b100001, 6'b000000, 1'b0, 0);  // lh
    issue(6'b101000, 6'b000000, 1'b0, 0);  // sb
    issue(6'b101001, 6'b000000, 1'b0, 0);  // sh
    issue(6'b000000, 6'b100011, 1'b0, 0);  // subu
    issue(6'b000000, 6'b100100, 1'b0, 0);  // and
    issue(6'b000000, 6'b100101, 1'b0, 0);  // or
    issue(6'b000000, 6'b100110, 1'b0, 0);  // xor
    issue(6'b000000, 6'b000000, 1'b0, 0);  // sll
    issue(6'b000000, 6'b011000, 1'b0, 5);  // mult, busy long
    issue(6'b000000, 6'b011001, 1'b0, 0);  // multu, busy already low
    issue(6'b000000, 6'b010000, 1'b0, 2);  // mfhi stalls
    issue(6'b000000, 6'b010010, 1'b0, 0);  // mflo
    issue(6'b111111, 6'b000000, 1'b0, 0);  // illegal op
    issue(6'b000000, 6'b111111, 1'b0, 0);  // illegal funct

    // Store cut by an asynchronous reset in MEM cycle 7: no mem_write ever
    bus.op = 6'b101011; bus.funct = 6'b000000; bus.zero = 1'b0; bus.mdu_busy = 1'b0;
    mw_seen = 0;
    for (int k = 1; k < 7; k++) begin
      #1 if (bus.mem_write) mw_seen++;
      @(negedge clk);
    end
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1 check_quiet("async_reset_mid_mem");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 if (bus.mem_write) mw_seen++;
    end
    chk("aborted_store_mem_write", 32'(mw_seen), 32'd0);
    release_reset();

    // Random instruction stream, including random (mostly illegal) encodings
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) pick = 12'($urandom_range(0, 4095));
      else pick = legal_tab[$urandom_range(0, 24)];
      issue(pick[11:6], pick[5:0], 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    report_and_finish();
  end

  // Global watchdog
  initial begin
    #200000;
    chk("global_timeout", 32'd0, 32'd1);
    report_and_finish();
  end

endmodule
